// File: rtl/wavelet_readout_deser.sv
// wavelet_readout_deser
// Receive end of the wavelet-core comparator readout chain. Four serial lanes
// (I1, I0, Q1, Q0) are deserialized into one parallel word per frame. Each word
// is then queued in a small FIFO that has a valid/ready handshake. The block also
// reports dropped frames (overflow), truncated frames (frame_err) and an
// accepted-frame counter.
module wavelet_readout_deser #(
    parameter int N_CORES    = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                   clk_master,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   frame_sync,
    input  logic [1:0]             read_out_I,
    input  logic [1:0]             read_out_Q,
    output logic [4*N_CORES-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic                   overflow,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int IDX_W   = $clog2(N_CORES);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_CORES - 1);
    localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Lane 3 holds I1, lane 2 I0, lane 1 Q1 and lane 0 Q0. Because of this order,
    // the packed vector is already the output word {I1,I0,Q1,Q0}.
    logic [3:0][N_CORES-1:0] sr_q, sr_d;

    logic [4*N_CORES-1:0] mem_q [FIFO_DEPTH];
    logic [4*N_CORES-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]   level_q, level_d;

    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             overflow_q, overflow_d;
    logic             frame_err_q, frame_err_d;

    logic [3:0]              sample;
    logic [3:0][N_CORES-1:0] shifted;
    logic [3:0][N_CORES-1:0] fresh;
    logic [4*N_CORES-1:0]    word_in;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    push_ok;
    logic                    drop;

    assign sample = {read_out_I, read_out_Q};

    // The first received bit enters at the LSB and is shifted up, so after
    // N_CORES bits it is the MSB of its lane.
    always_comb begin
        shifted = '0;
        fresh   = '0;
        for (int l = 0; l < 4; l++) begin
            shifted[l] = {sr_q[l][N_CORES-2:0], sample[l]};
            fresh[l]   = {{(N_CORES-1){1'b0}}, sample[l]};
        end
    end

    // Frame FSM. The en-low abort wins over a mid-frame sync. A mid-frame sync
    // restarts the frame with the current bits as bit 0.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sr_d        = sr_q;
        frame_err_d = frame_err_q;
        push        = 1'b0;
        word_in     = '0;
        case (state_q)
            IDLE: begin
                if (en && frame_sync) begin
                    sr_d    = fresh;
                    idx_d   = IDX_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!en) begin
                    sr_d    = '0;
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (frame_sync) begin
                    frame_err_d = 1'b1;
                    sr_d        = fresh;
                    idx_d       = IDX_W'(1);
                end else if (idx_q == LAST_IDX) begin
                    push    = 1'b1;
                    word_in = shifted;
                    sr_d    = '0;
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    sr_d  = shifted;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                sr_d    = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping. A pop frees a slot on the same edge, so a push into a
    // full FIFO is still accepted when the consumer is popping.
    always_comb begin
        pop     = (level_q != '0) && out_ready;
        full    = (level_q == FULL_LVL);
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = word_in;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase

        frame_cnt_d = frame_cnt_q + CNT_W'(push_ok);
        overflow_d  = overflow_q | drop;
    end

    // State registers. The sticky flags are cleared only by reset.
    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sr_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sr_q        <= sr_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign frame_cnt = frame_cnt_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_wavelet_readout_deser.sv
// Testbench for wavelet_readout_deser with N_CORES=4 and FIFO_DEPTH=2.
// A second instance with CNT_W=2 shares the same stimulus so that counter
// wrap-around can be observed.
`timescale 1ns/1ps
module tb_wavelet_readout_deser;

    logic        clk_master = 1'b0;
    logic        rst;
    logic        en;
    logic        frame_sync;
    logic [1:0]  read_out_I;
    logic [1:0]  read_out_Q;
    logic        out_ready;

    logic [15:0] out_data,  out_data2;
    logic        out_valid, out_valid2;
    logic [15:0] frame_cnt;
    logic [1:0]  frame_cnt2;
    logic        overflow,  overflow2;
    logic        frame_err, frame_err2;
    logic        busy,      busy2;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    wavelet_readout_deser #(.N_CORES(4), .FIFO_DEPTH(2), .CNT_W(16)) dut (
        .clk_master(clk_master), .rst(rst), .en(en), .frame_sync(frame_sync),
        .read_out_I(read_out_I), .read_out_Q(read_out_Q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_cnt(frame_cnt), .overflow(overflow), .frame_err(frame_err), .busy(busy)
    );

    wavelet_readout_deser #(.N_CORES(4), .FIFO_DEPTH(2), .CNT_W(2)) dut2 (
        .clk_master(clk_master), .rst(rst), .en(en), .frame_sync(frame_sync),
        .read_out_I(read_out_I), .read_out_Q(read_out_Q),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
        .frame_cnt(frame_cnt2), .overflow(overflow2), .frame_err(frame_err2), .busy(busy2)
    );

    always #5 clk_master = ~clk_master;

    // Reference model: the frame is a list of 4-bit lane samples, and the FIFO is
    // a queue of finished words.
    logic [3:0]  m_bits [$];
    logic        m_active;
    logic [15:0] m_fifo [$];
    logic [15:0] m_cnt;
    logic        m_ovf;
    logic        m_err;

    task automatic modelStep();
        logic [3:0]  s;
        logic [15:0] w;
        bit          pop;
        bit          full;
        bit          done;
        s    = {read_out_I, read_out_Q};
        w    = '0;
        done = 0;
        pop  = (m_fifo.size() > 0) && out_ready;
        full = (m_fifo.size() == 2);
        if (!m_active) begin
            if (en && frame_sync) begin
                m_bits.delete();
                m_bits.push_back(s);
                m_active = 1'b1;
            end
        end else if (!en) begin
            m_active = 1'b0;
            m_bits.delete();
        end else if (frame_sync) begin
            m_err = 1'b1;
            m_bits.delete();
            m_bits.push_back(s);
        end else begin
            m_bits.push_back(s);
            if (m_bits.size() == 4) begin
                for (int k = 0; k < 4; k++)
                    for (int l = 0; l < 4; l++)
                        w[l*4 + (3-k)] = m_bits[k][l];
                done     = 1;
                m_active = 1'b0;
                m_bits.delete();
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (done) begin
            if (!full || pop) begin
                m_fifo.push_back(w);
                m_cnt = m_cnt + 16'd1;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    always @(posedge clk_master or posedge rst) begin
        if (rst) begin
            m_bits.delete();
            m_fifo.delete();
            m_active = 1'b0;
            m_cnt    = '0;
            m_ovf    = 1'b0;
            m_err    = 1'b0;
        end else begin
            modelStep();
        end
    end

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Compares both instances against the model.
    task automatic checkOutput();
        logic mv;
        mv = (m_fifo.size() > 0);
        checkEq("valid",  32'(out_valid),  32'(mv));
        checkEq("valid2", 32'(out_valid2), 32'(mv));
        checkEq("busy",   32'(busy),       32'(m_active));
        checkEq("busy2",  32'(busy2),      32'(m_active));
        checkEq("cnt",    32'(frame_cnt),  32'(m_cnt));
        checkEq("cnt2",   32'(frame_cnt2), 32'(m_cnt[1:0]));
        checkEq("ovf",    32'(overflow),   32'(m_ovf));
        checkEq("ovf2",   32'(overflow2),  32'(m_ovf));
        checkEq("err",    32'(frame_err),  32'(m_err));
        checkEq("err2",   32'(frame_err2), 32'(m_err));
        if (mv) begin
            checkEq("data",  32'(out_data),  32'(m_fifo[0]));
            checkEq("data2", 32'(out_data2), 32'(m_fifo[0]));
        end
    endtask

    task automatic setIn(input logic fs, input logic e, input logic [1:0] ri,
                         input logic [1:0] rq, input logic rdy);
        frame_sync = fs;
        en         = e;
        read_out_I = ri;
        read_out_Q = rq;
        out_ready  = rdy;
    endtask

    task automatic tick();
        @(posedge clk_master);
        #1;
        checkOutput();
    endtask

    typedef struct packed {
        logic        fs;
        logic        en;
        logic [1:0]  ri;
        logic [1:0]  rq;
        logic        rdy;
        logic        exp_valid;
        logic        chk_data;
        logic [15:0] exp_data;
        logic        exp_busy;
        logic [15:0] exp_cnt;
    } vec_t;

    task automatic applyStimulus(input vec_t v);
        setIn(v.fs, v.en, v.ri, v.rq, v.rdy);
        tick();
        checkEq("tbl_valid", 32'(out_valid), 32'(v.exp_valid));
        checkEq("tbl_busy",  32'(busy),      32'(v.exp_busy));
        checkEq("tbl_cnt",   32'(frame_cnt), 32'(v.exp_cnt));
        if (v.chk_data) checkEq("tbl_data", 32'(out_data), 32'(v.exp_data));
    endtask

    task automatic sendFrame(input logic [15:0] w, input logic rdy_body, input logic rdy_last);
        for (int k = 0; k < 4; k++) begin
            setIn(k == 0, 1'b1, {w[15-k], w[11-k]}, {w[7-k], w[3-k]},
                  (k == 3) ? rdy_last : rdy_body);
            tick();
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            setIn(1'b0, 1'b1, 2'($urandom), 2'($urandom), rdy);
            tick();
        end
    endtask

    task automatic doReset();
        setIn(1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        rst = 1'b1;
        #2;
        checkEq("rst_valid", 32'(out_valid), 32'd0);
        checkEq("rst_data",  32'(out_data),  32'd0);
        checkEq("rst_busy",  32'(busy),      32'd0);
        checkEq("rst_cnt",   32'(frame_cnt), 32'd0);
        checkEq("rst_ovf",   32'(overflow),  32'd0);
        checkEq("rst_err",   32'(frame_err), 32'd0);
        @(posedge clk_master);
        #1;
        rst = 1'b0;
    endtask

    vec_t            tbl [5];
    logic [1:0]      cnt2_exp [5];

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        tbl[0] = '{fs:1'b1, en:1'b1, ri:2'b10, rq:2'b10, rdy:1'b1, exp_valid:1'b0, chk_data:1'b0, exp_data:16'h0000, exp_busy:1'b1, exp_cnt:16'd0};
        tbl[1] = '{fs:1'b0, en:1'b1, ri:2'b00, rq:2'b11, rdy:1'b1, exp_valid:1'b0, chk_data:1'b0, exp_data:16'h0000, exp_busy:1'b1, exp_cnt:16'd0};
        tbl[2] = '{fs:1'b0, en:1'b1, ri:2'b10, rq:2'b10, rdy:1'b1, exp_valid:1'b0, chk_data:1'b0, exp_data:16'h0000, exp_busy:1'b1, exp_cnt:16'd0};
        tbl[3] = '{fs:1'b0, en:1'b1, ri:2'b11, rq:2'b10, rdy:1'b1, exp_valid:1'b1, chk_data:1'b1, exp_data:16'hB1F4, exp_busy:1'b0, exp_cnt:16'd1};
        tbl[4] = '{fs:1'b0, en:1'b1, ri:2'b00, rq:2'b00, rdy:1'b1, exp_valid:1'b0, chk_data:1'b0, exp_data:16'h0000, exp_busy:1'b0, exp_cnt:16'd1};
        cnt2_exp[0] = 2'd1; cnt2_exp[1] = 2'd2; cnt2_exp[2] = 2'd3;
        cnt2_exp[3] = 2'd0; cnt2_exp[4] = 2'd1;

        setIn(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk_master);
        #1;
        rst = 1'b0;
        idle(2, 1'b0);

        // Reset while a frame is shifting and the FIFO holds one word.
        $display("[TB] reset during SHIFT");
        sendFrame(16'hA5C3, 1'b0, 1'b0);
        setIn(1'b1, 1'b1, 2'b01, 2'b10, 1'b0);
        tick();
        setIn(1'b0, 1'b1, 2'b11, 2'b00, 1'b0);
        tick();
        checkEq("pre_rst_busy",  32'(busy),      32'd1);
        checkEq("pre_rst_valid", 32'(out_valid), 32'd1);
        doReset();
        idle(1, 1'b0);

        // Basic frame driven from the vector table.
        $display("[TB] basic frame table");
        for (int i = 0; i < 5; i++) applyStimulus(tbl[i]);

        // Three back-to-back frames with the consumer stalled, then pop and push on the same edge.
        $display("[TB] overflow and simultaneous push/pop");
        doReset();
        sendFrame(16'h1234, 1'b0, 1'b0);
        sendFrame(16'h5678, 1'b0, 1'b0);
        sendFrame(16'h9ABC, 1'b0, 1'b0);
        checkEq("ovf_set",   32'(overflow),  32'd1);
        checkEq("ovf_cnt",   32'(frame_cnt), 32'd2);
        checkEq("ovf_head",  32'(out_data),  32'h1234);
        sendFrame(16'hDEF0, 1'b0, 1'b1);
        checkEq("pp_cnt",    32'(frame_cnt), 32'd3);
        checkEq("pp_head",   32'(out_data),  32'h5678);
        idle(1, 1'b1);
        checkEq("pp_next",   32'(out_data),  32'hDEF0);
        idle(1, 1'b1);
        checkEq("pp_empty",  32'(out_valid), 32'd0);

        // A second sync at bit index 2 restarts the frame.
        $display("[TB] mid-frame sync");
        doReset();
        setIn(1'b1, 1'b1, 2'b11, 2'b11, 1'b1);
        tick();
        setIn(1'b0, 1'b1, 2'b00, 2'b11, 1'b1);
        tick();
        sendFrame(16'h3C5A, 1'b1, 1'b1);
        checkEq("resync_err",  32'(frame_err), 32'd1);
        checkEq("resync_data", 32'(out_data),  32'h3C5A);
        checkEq("resync_cnt",  32'(frame_cnt), 32'd1);
        idle(1, 1'b1);
        checkEq("resync_one",  32'(out_valid), 32'd0);

        // en dropped at bit index 2 discards the partial frame silently.
        $display("[TB] enable abort");
        doReset();
        setIn(1'b1, 1'b1, 2'b10, 2'b01, 1'b1);
        tick();
        setIn(1'b0, 1'b1, 2'b01, 2'b10, 1'b1);
        tick();
        setIn(1'b0, 1'b0, 2'b11, 2'b11, 1'b1);
        tick();
        checkEq("abort_busy", 32'(busy), 32'd0);
        idle(2, 1'b1);
        checkEq("abort_valid", 32'(out_valid), 32'd0);
        checkEq("abort_cnt",   32'(frame_cnt), 32'd0);
        checkEq("abort_err",   32'(frame_err), 32'd0);
        sendFrame(16'h8E17, 1'b1, 1'b1);
        checkEq("abort_data",  32'(out_data),  32'h8E17);
        checkEq("abort_cnt1",  32'(frame_cnt), 32'd1);
        checkEq("abort_ovf",   32'(overflow),  32'd0);

        // Counter wrap on the CNT_W=2 instance.
        $display("[TB] counter wrap");
        doReset();
        for (int i = 0; i < 5; i++) begin
            sendFrame(16'($urandom), 1'b1, 1'b1);
            checkEq("wrap_cnt2", 32'(frame_cnt2), 32'(cnt2_exp[i]));
        end
        idle(2, 1'b1);

        // Random traffic checked cycle by cycle against the model.
        $display("[TB] random traffic");
        doReset();
        for (int c = 0; c < 600; c++) begin
            setIn(($urandom % 5) == 0, ($urandom % 16) != 0,
                  2'($urandom), 2'($urandom), ($urandom % 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
